// File: rtl/sync_down_counter.sv
// -----------------------------------------------------------------------------
// sync_down_counter
//
// Loadable down-counter with one-shot and periodic (auto-reload) modes.
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   reset        - synchronous active-high reset (highest priority)
//   load         - loads load_val into the count and the reload register
//   load_val     - start / reload value, WIDTH bits
//   en           - count enable, one decrement per enabled cycle in RUN
//   auto_reload  - 1 = periodic, 0 = one-shot; sampled at the terminal cycle
//   q            - current count (registered)
//   zero         - high when q == 0 (combinational decode of the q register)
//   borrow       - registered single-cycle terminal-count pulse
//   done         - high while in EXPIRED (registered)
//   running      - high while in RUN (registered)
// -----------------------------------------------------------------------------
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow,
    output logic             done,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic             running_q, running_d;

    // Next-state, next-count and output-flag computation.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        borrow_d  = 1'b0;

        if (load) begin
            // Load wins over en in every state and suppresses a coincident borrow.
            count_d  = load_val;
            reload_d = load_val;
            state_d  = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (en) begin
                        if (count_q != {WIDTH{1'b0}}) begin
                            count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            // Terminal cycle: auto_reload is only looked at here.
                            borrow_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = {WIDTH{1'b0}};
                                state_d = ST_EXPIRED;
                            end
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_EXPIRED: begin
                    count_d = {WIDTH{1'b0}};
                end
                default: begin
                    // Unreachable encoding: fall back to a safe idle state.
                    state_d = ST_IDLE;
                    count_d = {WIDTH{1'b0}};
                end
            endcase
        end

        // done/running are registered so they line up with q and borrow.
        done_d    = (state_d == ST_EXPIRED);
        running_d = (state_d == ST_RUN);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= {WIDTH{1'b0}};
            reload_q  <= {WIDTH{1'b0}};
            borrow_q  <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            borrow_q  <= borrow_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    assign q       = count_q;
    assign zero    = (count_q == {WIDTH{1'b0}});
    assign borrow  = borrow_q;
    assign done    = done_q;
    assign running = running_q;

endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port load, input, 1 bit: loads load_val into the count and the reload register.
REQ-005 SHALL have port load_val, input, WIDTH bits: the start/reload value.
REQ-006 SHALL have port en, input, 1 bit: count enable, one decrement per enabled cycle.
REQ-007 SHALL have port auto_reload, input, 1 bit: 1 = periodic mode, 0 = one-shot mode.
REQ-008 SHALL have port q, output, WIDTH bits: the current count, registered.
REQ-009 SHALL have port zero, output, 1 bit: high when q == 0, decoded combinationally from q.
REQ-010 SHALL have port borrow, output, 1 bit: registered single-cycle terminal-count pulse.
REQ-011 SHALL have port done, output, 1 bit: high while in state EXPIRED.
REQ-012 SHALL have port running, output, 1 bit: high while in state RUN.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, EXPIRED.
REQ-014 SHALL make load take priority over en in every state.
- Next edge: q <= load_val, reload register <= load_val, state <= RUN, borrow <= 0.
REQ-015 SHALL in IDLE hold q and ignore en; the only exit is load.
REQ-016 SHALL in RUN with en=1 and q != 0 set q <= q-1, with borrow 0 and state unchanged.
REQ-017 SHALL in RUN with en=1 and q == 0 assert borrow for exactly the next cycle, then:
- auto_reload=1: q <= reload register, state stays RUN.
- auto_reload=0: q stays 0, state <= EXPIRED.
REQ-018 SHALL in RUN with en=0 hold q and keep borrow at 0.
REQ-019 SHALL in EXPIRED hold q = 0, ignore en, keep done=1, and exit only on load.
REQ-020 SHALL sample auto_reload at the terminal cycle only; changes mid-count take effect at the next terminal cycle.
REQ-021 SHALL give a period of (reload value + 1) enabled cycles between borrow pulses in periodic mode.
REQ-022 SHALL, for reload value 0 in periodic mode, pulse borrow on every enabled cycle with q held at 0.
REQ-023 SHALL never wrap q from 0 to all-ones; the decrement is unsigned and modulo-free.
REQ-024 SHALL, on load coinciding with a terminal cycle, suppress borrow and apply the load (REQ-014).
REQ-025 SHALL have a latency of one clock from any input to q, borrow, done and running.

Reset
REQ-026 SHALL on reset=1 at a rising edge set q=0, reload register=0, borrow=0, state=IDLE.
- Resulting outputs: zero=1, done=0, running=0.
REQ-027 SHALL give reset priority over load and en, including mid-count and in the terminal cycle.
REQ-028 SHALL have no asynchronous reset path; reset asserted between edges has no effect until the next edge.

Verification
REQ-029 SHALL cover one-shot: load 3, auto_reload=0, en=1 held.
- q = 3,2,1,0; borrow pulses once on the edge after q=0.
- Then done=1, q stays 0 for 10 further cycles.
REQ-030 SHALL cover periodic: load 2, auto_reload=1, en=1 for 9 cycles.
- q = 2,1,0,2,1,0,2,1,0; borrow asserted after each 0, 3 cycles apart.
REQ-031 SHALL cover enable gating: load 5, en toggled 1,0,1,0.
- q = 5,4,4,3,3; borrow stays 0; running=1 throughout.
REQ-032 SHALL cover load on terminal cycle: q=0, en=1, load=1, load_val=7, same cycle.
- Next: q=7, borrow=0, state RUN.
REQ-033 SHALL cover reset mid-count: load 9, 4 enabled cycles, reset for 1 cycle.
- Next: q=0, borrow=0, running=0, done=0; en=1 thereafter leaves q at 0 (IDLE).
REQ-034 SHALL cover the zero-reload corner: WIDTH=4, load 0, auto_reload=1, en=1 for 4 cycles.
- borrow=1 on all 4 cycles; q=0 throughout; no wrap to 15.
